fg_bbox_tracker: RTL

//  Downstream consumer of the background-subtraction stage. Takes its per-pixel foreground flag stream, raster-ordered
//  and qualified by valid, and builds per-frame foreground statistics: bounding box, pixel count and integer centroid.

---
 rtl/fg_pkg.sv | 36 +++
 rtl/seq_divider.sv | 85 ++++++++
 rtl/fg_bbox_tracker.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fg_pkg.sv
// ---------------------------------------------------------------------------
// fg_pkg
//  Shared definitions for the foreground bounding-box tracker.
//  - fsm_t        : result-engine state (IDLE, LOAD, DIV_X, DIV_Y, PUB)
//  - width helpers: derive raster/count/sum widths from the active frame size
//  - FG_*_W       : widths for the default 640x480 frame
// ---------------------------------------------------------------------------
package fg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DIV_X = 3'd2,
        DIV_Y = 3'd3,
        PUB   = 3'd4
    } fsm_t;

    function automatic int fg_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int fg_cnt_w(input int h, input int v);
        return $clog2(h * v + 1);
    endfunction

    // Sum of coordinates never exceeds count * max coordinate.
    function automatic int fg_sum_w(input int h, input int v);
        return fg_cnt_w(h, v) + fg_max($clog2(h), $clog2(v));
    endfunction

    localparam int FG_X_W   = $clog2(640);
    localparam int FG_Y_W   = $clog2(480);
    localparam int FG_CNT_W = fg_cnt_w(640, 480);
    localparam int FG_SUM_W = fg_sum_w(640, 480);

endpackage

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//  Unsigned restoring divider, one quotient bit per clock. The first bit is
//  resolved on the edge that accepts i_start, so o_done pulses exactly N
//  cycles after the cycle in which i_start is high. N must be >= 2.
//  Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : load i_num / i_den and begin dividing
//   i_num [N]      : dividend
//   i_den [D]      : divisor (non-zero)
//   o_busy         : division in progress
//   o_done         : one-cycle pulse, o_quot valid
//   o_quot [N]     : quotient, held until the next start
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int N = 16,
    parameter int D = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_num,
    input  logic [D-1:0] i_den,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_quot
);

    localparam int CW = $clog2(N + 1);

    logic [D-1:0]  r_rem;
    logic [N-1:0]  r_q;
    logic [D-1:0]  r_den;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    // One restoring step. r_q doubles as the dividend shift register: its MSB
    // feeds the remainder and the new quotient bit enters at the LSB. Since
    // rem < den, the shifted trial is < 2*den and the top bit of the
    // difference is a reliable borrow flag.
    function automatic logic [D+N-1:0] div_step(input logic [D-1:0] rem,
                                                input logic [N-1:0] q,
                                                input logic [D-1:0] den);
        logic [D:0] sh;
        logic [D:0] diff;
        sh   = {rem, q[N-1]};
        diff = sh - {1'b0, den};
        if (!diff[D])
            return {diff[D-1:0], q[N-2:0], 1'b1};
        else
            return {sh[D-1:0], q[N-2:0], 1'b0};
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                {r_rem, r_q} <= div_step('0, i_num, i_den);
                r_den        <= i_den;
                r_cnt        <= CW'(N - 1);
                r_busy       <= 1'b1;
            end else if (r_busy) begin
                {r_rem, r_q} <= div_step(r_rem, r_q, r_den);
                r_cnt        <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_quot = r_q;

endmodule

// File: rtl/fg_bbox_tracker.sv
// ---------------------------------------------------------------------------
// fg_bbox_tracker
//  Consumes the raster-ordered foreground flag stream and publishes, once per
//  frame, the bounding box, pixel count and integer centroid of the
//  foreground pixels. The centroid uses one shared sequential divider, first
//  for x then for y.
//  Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_valid               : pixel strobe
//   i_sof                 : with i_valid, this pixel is (0,0)
//   i_fg                  : foreground flag of the current pixel
//   o_done                : one-cycle pulse when result outputs update
//   o_found               : last frame had >= MIN_PIXELS foreground pixels
//   o_x_min/o_x_max       : bounding box columns
//   o_y_min/o_y_max       : bounding box rows
//   o_count               : foreground pixel count of last frame
//   o_cx/o_cy             : centroid, floor(sum/count)
//   o_overrun             : sticky, a frame ended while a result was pending
// ---------------------------------------------------------------------------
module fg_bbox_tracker
    import fg_pkg::*;
#(
    parameter int  H_ACTIVE   = 640,
    parameter int  V_ACTIVE   = 480,
    parameter int  MIN_PIXELS = 64,
    localparam int X_W        = $clog2(H_ACTIVE),
    localparam int Y_W        = $clog2(V_ACTIVE),
    localparam int CNT_W      = fg_cnt_w(H_ACTIVE, V_ACTIVE)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_sof,
    input  logic             i_fg,
    output logic             o_done,
    output logic             o_found,
    output logic [X_W-1:0]   o_x_min,
    output logic [X_W-1:0]   o_x_max,
    output logic [Y_W-1:0]   o_y_min,
    output logic [Y_W-1:0]   o_y_max,
    output logic [CNT_W-1:0] o_count,
    output logic [X_W-1:0]   o_cx,
    output logic [Y_W-1:0]   o_cy,
    output logic             o_overrun
);

    localparam int XY_W  = fg_max(X_W, Y_W);
    localparam int SUM_W = fg_sum_w(H_ACTIVE, V_ACTIVE);

    localparam logic [X_W-1:0]   X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]   Y_LAST = Y_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PIXELS);

    // Raster position and running accumulators
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] r_sx, r_sy;
    logic [X_W-1:0]   r_xmin, r_xmax;
    logic [Y_W-1:0]   r_ymin, r_ymax;

    // Snapshot of a finished frame, owned by the result engine
    logic [CNT_W-1:0] r_st_cnt;
    logic [SUM_W-1:0] r_st_sx, r_st_sy;
    logic [X_W-1:0]   r_st_xmin, r_st_xmax;
    logic [Y_W-1:0]   r_st_ymin, r_st_ymax;
    logic             r_st_found;

    fsm_t             r_state;
    logic             r_kick;
    logic [X_W-1:0]   r_qx;
    logic [Y_W-1:0]   r_qy;

    logic             r_o_done, r_o_found, r_o_overrun;
    logic [X_W-1:0]   r_o_xmin, r_o_xmax, r_o_cx;
    logic [Y_W-1:0]   r_o_ymin, r_o_ymax, r_o_cy;
    logic [CNT_W-1:0] r_o_count;

    logic             w_sof;
    logic [X_W-1:0]   w_px;
    logic [Y_W-1:0]   w_py;
    logic             w_fend;
    logic [CNT_W-1:0] w_b_cnt, w_n_cnt;
    logic [SUM_W-1:0] w_b_sx, w_b_sy, w_n_sx, w_n_sy;
    logic [X_W-1:0]   w_b_xmin, w_b_xmax, w_n_xmin, w_n_xmax;
    logic [Y_W-1:0]   w_b_ymin, w_b_ymax, w_n_ymin, w_n_ymax;

    logic             w_div_start, w_div_busy, w_div_done;
    logic [SUM_W-1:0] w_div_num, w_quot;
    logic             w_unused_quot_hi;

    // A start-of-frame pixel is taken as (0,0) against freshly cleared
    // accumulators, so the current pixel folds into a clean frame.
    always_comb begin
        w_sof    = i_valid & i_sof;
        w_px     = w_sof ? '0 : r_x;
        w_py     = w_sof ? '0 : r_y;
        w_b_cnt  = w_sof ? '0 : r_cnt;
        w_b_sx   = w_sof ? '0 : r_sx;
        w_b_sy   = w_sof ? '0 : r_sy;
        w_b_xmin = w_sof ? '1 : r_xmin;
        w_b_xmax = w_sof ? '0 : r_xmax;
        w_b_ymin = w_sof ? '1 : r_ymin;
        w_b_ymax = w_sof ? '0 : r_ymax;

        w_n_cnt  = w_b_cnt;
        w_n_sx   = w_b_sx;
        w_n_sy   = w_b_sy;
        w_n_xmin = w_b_xmin;
        w_n_xmax = w_b_xmax;
        w_n_ymin = w_b_ymin;
        w_n_ymax = w_b_ymax;
        if (i_fg) begin
            w_n_cnt = w_b_cnt + CNT_W'(1);
            w_n_sx  = w_b_sx + SUM_W'(w_px);
            w_n_sy  = w_b_sy + SUM_W'(w_py);
            if (w_px < w_b_xmin) w_n_xmin = w_px;
            if (w_px > w_b_xmax) w_n_xmax = w_px;
            if (w_py < w_b_ymin) w_n_ymin = w_py;
            if (w_py > w_b_ymax) w_n_ymax = w_py;
        end

        w_fend = i_valid & (w_px == X_LAST) & (w_py == Y_LAST);
    end

    // Raster and accumulators. On frame end the totals (including the final
    // pixel) go straight to the snapshot and the accumulators clear on the
    // same edge, so a following frame can start on the very next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_cnt  <= '0;
            r_sx   <= '0;
            r_sy   <= '0;
            r_xmin <= '1;
            r_xmax <= '0;
            r_ymin <= '1;
            r_ymax <= '0;
        end else if (i_valid) begin
            if (w_px == X_LAST) begin
                r_x <= '0;
                r_y <= (w_py == Y_LAST) ? '0 : w_py + Y_W'(1);
            end else begin
                r_x <= w_px + X_W'(1);
                r_y <= w_py;
            end

            if (w_fend) begin
                r_cnt  <= '0;
                r_sx   <= '0;
                r_sy   <= '0;
                r_xmin <= '1;
                r_xmax <= '0;
                r_ymin <= '1;
                r_ymax <= '0;
            end else begin
                r_cnt  <= w_n_cnt;
                r_sx   <= w_n_sx;
                r_sy   <= w_n_sy;
                r_xmin <= w_n_xmin;
                r_xmax <= w_n_xmax;
                r_ymin <= w_n_ymin;
                r_ymax <= w_n_ymax;
            end
        end
    end

    // The divider is started once from r_kick (first cycle of DIV_X) and
    // again straight off the x-done pulse for y; r_kick selects the dividend.
    assign w_div_start = ~w_div_busy & (r_kick | ((r_state == DIV_X) & w_div_done));
    assign w_div_num   = r_kick ? r_st_sx : r_st_sy;

    seq_divider #(
        .N (SUM_W),
        .D (CNT_W)
    ) u_div (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_div_start),
        .i_num   (w_div_num),
        .i_den   (r_st_cnt),
        .o_busy  (w_div_busy),
        .o_done  (w_div_done),
        .o_quot  (w_quot)
    );

    // Centroids are always below the frame size, so the high quotient bits
    // are zero and simply dropped.
    assign w_unused_quot_hi = |w_quot[SUM_W-1:XY_W];

    // Result engine: snapshot, divide x, divide y, publish.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_kick      <= 1'b0;
            r_st_cnt    <= '0;
            r_st_sx     <= '0;
            r_st_sy     <= '0;
            r_st_xmin   <= '0;
            r_st_xmax   <= '0;
            r_st_ymin   <= '0;
            r_st_ymax   <= '0;
            r_st_found  <= 1'b0;
            r_qx        <= '0;
            r_qy        <= '0;
            r_o_done    <= 1'b0;
            r_o_found   <= 1'b0;
            r_o_overrun <= 1'b0;
            r_o_xmin    <= '0;
            r_o_xmax    <= '0;
            r_o_ymin    <= '0;
            r_o_ymax    <= '0;
            r_o_count   <= '0;
            r_o_cx      <= '0;
            r_o_cy      <= '0;
        end else begin
            r_o_done <= 1'b0;
            r_kick   <= 1'b0;

            // A frame ending while a result is still pending is dropped.
            if (w_fend) begin
                if (r_state == IDLE) begin
                    r_st_cnt  <= w_n_cnt;
                    r_st_sx   <= w_n_sx;
                    r_st_sy   <= w_n_sy;
                    r_st_xmin <= w_n_xmin;
                    r_st_xmax <= w_n_xmax;
                    r_st_ymin <= w_n_ymin;
                    r_st_ymax <= w_n_ymax;
                end else begin
                    r_o_overrun <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_fend) r_state <= LOAD;
                end
                LOAD: begin
                    if (r_st_cnt < MIN_C) begin
                        r_st_found <= 1'b0;
                        r_state    <= PUB;
                    end else begin
                        r_st_found <= 1'b1;
                        r_kick     <= 1'b1;
                        r_state    <= DIV_X;
                    end
                end
                DIV_X: begin
                    if (w_div_done) begin
                        r_qx    <= w_quot[X_W-1:0];
                        r_state <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    if (w_div_done) begin
                        r_qy    <= w_quot[Y_W-1:0];
                        r_state <= PUB;
                    end
                end
                PUB: begin
                    r_o_done  <= 1'b1;
                    r_o_found <= r_st_found;
                    r_o_count <= r_st_cnt;
                    if (r_st_found) begin
                        r_o_xmin <= r_st_xmin;
                        r_o_xmax <= r_st_xmax;
                        r_o_ymin <= r_st_ymin;
                        r_o_ymax <= r_st_ymax;
                        r_o_cx   <= r_qx;
                        r_o_cy   <= r_qy;
                    end else begin
                        r_o_xmin <= '0;
                        r_o_xmax <= '0;
                        r_o_ymin <= '0;
                        r_o_ymax <= '0;
                        r_o_cx   <= '0;
                        r_o_cy   <= '0;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_done    = r_o_done;
    assign o_found   = r_o_found;
    assign o_x_min   = r_o_xmin;
    assign o_x_max   = r_o_xmax;
    assign o_y_min   = r_o_ymin;
    assign o_y_max   = r_o_ymax;
    assign o_count   = r_o_count;
    assign o_cx      = r_o_cx;
    assign o_cy      = r_o_cy;
    assign o_overrun = r_o_overrun;

endmodule
